// File: rtl/err_loc_collector_pkg.sv
// Shared definitions for the BCH error-location collector: default sizes
// used across the decoder and the collector state encoding.
package err_loc_collector_pkg;

    localparam int ELC_LOC_WIDTH = 10;
    localparam int ELC_T         = 8;
    localparam int ELC_DEG_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        DRAIN   = 2'd3
    } state_e;

endpackage

// File: rtl/err_loc_regfile.sv
// Small T-entry register file holding captured error locations.
// Single synchronous write port, single asynchronous read port, contents
// are not reset.
module err_loc_regfile #(
    parameter int LOC_WIDTH  = 10,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [LOC_WIDTH-1:0]  wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [LOC_WIDTH-1:0]  rd_data
);

    logic [LOC_WIDTH-1:0] mem_q [DEPTH];

    // Capture one location per write strobe; no reset so it maps to plain RAM-like flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/err_loc_collector.sv
// Collects Chien-search root positions during a sweep, checks the root count
// against the ELP degree, and streams the locations out on success.
module err_loc_collector
    import err_loc_collector_pkg::*;
#(
    parameter int LOC_WIDTH = ELC_LOC_WIDTH,
    parameter int T         = ELC_T,
    parameter int DEG_WIDTH = ELC_DEG_WIDTH
) (
    input  logic                 clk,
    input  logic                 in_ctr_Arst_n,
    input  logic                 in_ctr_Srst,
    input  logic                 in_ctr_en,
    input  logic                 in_ctr_init,
    input  logic [DEG_WIDTH-1:0] in_elp_deg,
    input  logic                 in_ctr_valid,
    input  logic [LOC_WIDTH-1:0] in_loc,
    input  logic                 in_ctr_done,
    input  logic                 in_rd_ready,
    output logic                 out_valid,
    output logic [LOC_WIDTH-1:0] out_loc,
    output logic                 out_last,
    output logic                 out_dec_done,
    output logic                 out_dec_fail,
    output logic [DEG_WIDTH-1:0] out_err_cnt,
    output logic                 out_busy
);

    localparam int                   ADDR_WIDTH = (T > 1) ? $clog2(T) : 1;
    localparam logic [DEG_WIDTH-1:0] T_CNT      = DEG_WIDTH'(T);

    state_e               state_q, state_d;
    logic [DEG_WIDTH-1:0] cnt_q, cnt_d;
    logic [DEG_WIDTH-1:0] rd_q, rd_d;
    logic [DEG_WIDTH-1:0] deg_q, deg_d;
    logic                 ovf_q, ovf_d;
    logic                 fail_q, fail_d;
    logic                 done_q, done_d;

    logic                 wr_en;
    logic [LOC_WIDTH-1:0] rd_data;
    logic [DEG_WIDTH-1:0] last_idx;
    logic                 check_fail;

    assign last_idx   = cnt_q - DEG_WIDTH'(1);
    assign check_fail = ovf_q || (cnt_q != deg_q);

    err_loc_regfile #(
        .LOC_WIDTH  (LOC_WIDTH),
        .DEPTH      (T),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regfile (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (cnt_q[ADDR_WIDTH-1:0]),
        .wr_data (in_loc),
        .rd_addr (rd_q[ADDR_WIDTH-1:0]),
        .rd_data (rd_data)
    );

    // Next-state logic: sync clear, then freeze, then init, then per-state sweep/check/drain.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        deg_d   = deg_q;
        ovf_d   = ovf_q;
        fail_d  = fail_q;
        done_d  = done_q;
        wr_en   = 1'b0;

        if (in_ctr_Srst) begin
            state_d = IDLE;
            cnt_d   = '0;
            rd_d    = '0;
            deg_d   = '0;
            ovf_d   = 1'b0;
            fail_d  = 1'b0;
            done_d  = 1'b0;
        end else if (in_ctr_en) begin
            done_d = 1'b0;
            if (in_ctr_init) begin
                deg_d   = in_elp_deg;
                cnt_d   = '0;
                rd_d    = '0;
                ovf_d   = 1'b0;
                fail_d  = 1'b0;
                state_d = COLLECT;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d = IDLE;
                    end
                    COLLECT: begin
                        if (in_ctr_valid) begin
                            if (cnt_q < T_CNT) begin
                                wr_en = 1'b1;
                                cnt_d = cnt_q + DEG_WIDTH'(1);
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                        if (in_ctr_done) begin
                            state_d = CHECK;
                        end
                    end
                    CHECK: begin
                        fail_d  = check_fail;
                        done_d  = 1'b1;
                        state_d = (!check_fail && (cnt_q != '0)) ? DRAIN : IDLE;
                    end
                    DRAIN: begin
                        if (in_rd_ready) begin
                            if (rd_q == last_idx) begin
                                state_d = IDLE;
                            end else begin
                                rd_d = rd_q + DEG_WIDTH'(1);
                            end
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // State, counters and verdict registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            deg_q   <= '0;
            ovf_q   <= 1'b0;
            fail_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            deg_q   <= deg_d;
            ovf_q   <= ovf_d;
            fail_q  <= fail_d;
            done_q  <= done_d;
        end
    end

    assign out_valid    = (state_q == DRAIN);
    assign out_loc      = out_valid ? rd_data : '0;
    assign out_last     = out_valid && (rd_q == last_idx);
    assign out_dec_done = done_q;
    assign out_dec_fail = fail_q;
    assign out_err_cnt  = cnt_q;
    assign out_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_err_loc_collector.sv
// Self-checking bench for err_loc_collector: directed table of sweeps,
// hand-written corner sequences and randomized sweeps against a count model.
module tb_err_loc_collector;

    localparam int LW = 10;
    localparam int TT = 8;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          in_ctr_Arst_n;
    logic          in_ctr_Srst;
    logic          in_ctr_en;
    logic          in_ctr_init;
    logic [DW-1:0] in_elp_deg;
    logic          in_ctr_valid;
    logic [LW-1:0] in_loc;
    logic          in_ctr_done;
    logic          in_rd_ready;
    logic          out_valid;
    logic [LW-1:0] out_loc;
    logic          out_last;
    logic          out_dec_done;
    logic          out_dec_fail;
    logic [DW-1:0] out_err_cnt;
    logic          out_busy;

    err_loc_collector #(
        .LOC_WIDTH (LW),
        .T         (TT),
        .DEG_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .in_ctr_Arst_n (in_ctr_Arst_n),
        .in_ctr_Srst   (in_ctr_Srst),
        .in_ctr_en     (in_ctr_en),
        .in_ctr_init   (in_ctr_init),
        .in_elp_deg    (in_elp_deg),
        .in_ctr_valid  (in_ctr_valid),
        .in_loc        (in_loc),
        .in_ctr_done   (in_ctr_done),
        .in_rd_ready   (in_rd_ready),
        .out_valid     (out_valid),
        .out_loc       (out_loc),
        .out_last      (out_last),
        .out_dec_done  (out_dec_done),
        .out_dec_fail  (out_dec_fail),
        .out_err_cnt   (out_err_cnt),
        .out_busy      (out_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cur_locs[$];

    typedef struct {
        int deg;
        int n;
        bit done_same;
        int stall;
        bit exp_fail;
        int exp_cnt;
    } vec_t;

    vec_t vecs[7];
    int   loc_tab[7][9];

    // Reference model: roots beyond T are dropped, any drop or count/degree mismatch fails.
    function automatic int model_cnt(input int n);
        return (n > TT) ? TT : n;
    endfunction

    function automatic bit model_fail(input int n, input int deg);
        return (n > TT) || (n != deg);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_loc"}, out_loc, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_done"}, out_dec_done, 0);
        check({tag, "_fail"}, out_dec_fail, 0);
        check({tag, "_cnt"}, out_err_cnt, 0);
        check({tag, "_busy"}, out_busy, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input int deg);
        in_ctr_init = 1'b1;
        in_elp_deg  = DW'(deg);
        step();
        in_ctr_init = 1'b0;
    endtask

    task automatic drive_step(input bit v, input int loc, input bit d);
        in_ctr_valid = v;
        in_loc       = LW'(loc);
        in_ctr_done  = d;
        step();
        in_ctr_valid = 1'b0;
        in_ctr_done  = 1'b0;
    endtask

    task automatic drive_gap();
        in_ctr_valid = 1'b0;
        in_loc       = LW'($urandom_range(0, 1023));
        step();
    endtask

    // One full sweep: init, roots from cur_locs with optional gaps, then done.
    task automatic applyStimulus(input int deg, input bit done_same, input int gap_max);
        do_init(deg);
        foreach (cur_locs[k]) begin
            repeat ($urandom_range(0, gap_max)) drive_gap();
            drive_step(1'b1, cur_locs[k], done_same && (k == cur_locs.size() - 1));
        end
        if (!done_same || cur_locs.size() == 0) begin
            drive_step(1'b0, 1022, 1'b1);
        end
    endtask

    // Called while the DUT sits in its check cycle; verifies verdict timing and drain beats.
    task automatic checkOutput(input bit exp_fail, input int exp_cnt, input int stall_first,
                               input int ready_pct);
        bit drain;
        int i;
        int cyc;
        int stall;
        bit rdy;
        drain = !exp_fail && (exp_cnt > 0);
        check("done_early", out_dec_done, 0);
        check("busy_check", out_busy, 1);
        step();
        check("done_pulse", out_dec_done, 1);
        check("dec_fail", out_dec_fail, exp_fail);
        check("err_cnt", out_err_cnt, exp_cnt);
        check("valid_start", out_valid, drain);
        if (drain) begin
            i     = 0;
            cyc   = 0;
            stall = stall_first;
            while (i < exp_cnt && cyc < 100) begin
                check("beat_valid", out_valid, 1);
                if (!out_valid) break;
                check("beat_loc", out_loc, cur_locs[i]);
                check("beat_last", out_last, (i == exp_cnt - 1) ? 1 : 0);
                if (i == 0 && stall > 0) begin
                    rdy = 1'b0;
                    stall--;
                end else begin
                    rdy = ($urandom_range(0, 99) < ready_pct);
                end
                in_rd_ready = rdy;
                step();
                cyc++;
                if (rdy) i++;
                if (cyc == 1) check("done_drop", out_dec_done, 0);
            end
            in_rd_ready = 1'b0;
            check("beat_count", i, exp_cnt);
            check("valid_end", out_valid, 0);
        end else begin
            step();
            check("done_drop", out_dec_done, 0);
            check("valid_none", out_valid, 0);
        end
        check("busy_end", out_busy, 0);
        check("fail_hold", out_dec_fail, exp_fail);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int deg;
        in_ctr_Arst_n = 1'b0;
        in_ctr_Srst   = 1'b0;
        in_ctr_en     = 1'b0;
        in_ctr_init   = 1'b0;
        in_elp_deg    = '0;
        in_ctr_valid  = 1'b0;
        in_loc        = '0;
        in_ctr_done   = 1'b0;
        in_rd_ready   = 1'b0;
        #12;
        check_all_zero("reset");
        in_ctr_Arst_n = 1'b1;
        in_ctr_en     = 1'b1;
        step();

        vecs[0] = '{deg: 3, n: 3, done_same: 0, stall: 0, exp_fail: 0, exp_cnt: 3};
        vecs[1] = '{deg: 2, n: 1, done_same: 0, stall: 0, exp_fail: 1, exp_cnt: 1};
        vecs[2] = '{deg: 8, n: 9, done_same: 0, stall: 0, exp_fail: 1, exp_cnt: 8};
        vecs[3] = '{deg: 2, n: 2, done_same: 0, stall: 3, exp_fail: 0, exp_cnt: 2};
        vecs[4] = '{deg: 1, n: 1, done_same: 1, stall: 0, exp_fail: 0, exp_cnt: 1};
        vecs[5] = '{deg: 0, n: 0, done_same: 0, stall: 0, exp_fail: 0, exp_cnt: 0};
        vecs[6] = '{deg: 8, n: 8, done_same: 1, stall: 1, exp_fail: 0, exp_cnt: 8};
        loc_tab = '{'{5, 100, 1000, 0, 0, 0, 0, 0, 0},
                    '{7, 0, 0, 0, 0, 0, 0, 0, 0},
                    '{1, 2, 3, 4, 5, 6, 7, 8, 9},
                    '{11, 22, 0, 0, 0, 0, 0, 0, 0},
                    '{1022, 0, 0, 0, 0, 0, 0, 0, 0},
                    '{0, 0, 0, 0, 0, 0, 0, 0, 0},
                    '{10, 20, 30, 40, 50, 60, 70, 80, 0}};

        for (int v = 0; v < 7; v++) begin
            cur_locs.delete();
            for (int j = 0; j < vecs[v].n; j++) cur_locs.push_back(loc_tab[v][j]);
            applyStimulus(vecs[v].deg, vecs[v].done_same, 0);
            checkOutput(vecs[v].exp_fail, vecs[v].exp_cnt, vecs[v].stall, 100);
        end

        // init while draining aborts the stream and starts a fresh sweep
        cur_locs = '{1, 2, 3};
        applyStimulus(3, 1'b0, 0);
        step();
        check("abort_first", out_loc, 1);
        in_rd_ready = 1'b1;
        step();
        in_rd_ready = 1'b0;
        check("abort_second", out_loc, 2);
        do_init(1);
        check("abort_valid", out_valid, 0);
        check("abort_busy", out_busy, 1);
        check("abort_cnt", out_err_cnt, 0);
        cur_locs = '{600};
        drive_step(1'b1, 600, 1'b1);
        checkOutput(1'b0, 1, 0, 100);

        // enable low freezes everything, including a pending init
        do_init(2);
        drive_step(1'b1, 33, 1'b0);
        check("freeze_pre", out_err_cnt, 1);
        in_ctr_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_ctr_valid = 1'b1;
            in_ctr_done  = 1'b1;
            in_ctr_init  = (k == 2);
            in_loc       = LW'($urandom_range(0, 1023));
            step();
            check("freeze_cnt", out_err_cnt, 1);
            check("freeze_busy", out_busy, 1);
            check("freeze_done", out_dec_done, 0);
        end
        in_ctr_valid = 1'b0;
        in_ctr_done  = 1'b0;
        in_ctr_init  = 1'b0;
        in_ctr_en    = 1'b1;
        cur_locs = '{33, 44};
        drive_step(1'b1, 44, 1'b1);
        checkOutput(1'b0, 2, 0, 100);

        // asynchronous reset mid-collect clears outputs without a clock edge
        do_init(4);
        drive_step(1'b1, 9, 1'b0);
        drive_step(1'b1, 10, 1'b0);
        check("areset_pre", out_err_cnt, 2);
        #2;
        in_ctr_Arst_n = 1'b0;
        #1;
        check_all_zero("areset");
        step();
        in_ctr_Arst_n = 1'b1;
        step();

        // synchronous clear wins even while enable is low
        do_init(4);
        drive_step(1'b1, 9, 1'b0);
        in_ctr_en   = 1'b0;
        in_ctr_Srst = 1'b1;
        step();
        in_ctr_Srst = 1'b0;
        in_ctr_en   = 1'b1;
        check("srst_busy", out_busy, 0);
        check("srst_cnt", out_err_cnt, 0);

        // valid/done outside a sweep are ignored
        drive_step(1'b1, 77, 1'b1);
        drive_step(1'b1, 78, 1'b1);
        check("idle_busy", out_busy, 0);
        check("idle_cnt", out_err_cnt, 0);
        check("idle_done", out_dec_done, 0);

        // randomized sweeps against the count model
        for (int r = 0; r < 30; r++) begin
            n = $urandom_range(0, 10);
            cur_locs.delete();
            for (int j = 0; j < n; j++) cur_locs.push_back($urandom_range(0, 1023));
            if ($urandom_range(0, 2) != 0) deg = model_cnt(n);
            else deg = $urandom_range(0, TT);
            applyStimulus(deg, $urandom_range(0, 1) == 1, 2);
            checkOutput(model_fail(n, deg), model_cnt(n), $urandom_range(0, 2), 60);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
